// File: rtl/rca_profile_scanner.sv
// rtl/rca_profile_scanner.sv - profile cache walker: lock, read every entry, keep the hottest, optionally unlock
module rca_profile_scanner #(
  parameter int NUM_PROFILER_ENTRIES = 8,
  parameter int XLEN = 32,
  parameter int COUNT_W = 8,
  parameter int ID_W = 3,
  parameter logic [ID_W-1:0] SCAN_ID = '0,
  localparam int IDX_W = (NUM_PROFILER_ENTRIES > 1) ? $clog2(NUM_PROFILER_ENTRIES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               unlock_on_finish,
  input  logic               issue_ready,
  output logic               issue_new_request,
  output logic [ID_W-1:0]    issue_id,
  output logic               toggle_lock,
  output logic [1:0]         field_id,
  output logic [IDX_W-1:0]   entry_index,
  input  logic               wb_done,
  input  logic [XLEN-1:0]    wb_rd,
  output logic               wb_ack,
  output logic               busy,
  output logic               done,
  output logic               locked,
  output logic               best_valid,
  output logic [IDX_W-1:0]   best_index,
  output logic [COUNT_W-1:0] best_count,
  output logic [XLEN-1:0]    best_addr
);

  typedef enum logic [3:0] {
    IDLE, LOCK_REQ, LOCK_WAIT, RD_VALID, RD_COUNT, RD_ADDR,
    NEXT, UNLOCK_REQ, UNLOCK_WAIT, FINISH
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PROFILER_ENTRIES - 1);
  localparam logic [1:0]       FIELD_ADDR  = 2'd0;
  localparam logic [1:0]       FIELD_VALID = 2'd1;
  localparam logic [1:0]       FIELD_COUNT = 2'd2;

  state_t             state, state_nxt;
  logic               outstanding;
  logic               unlock_latched;
  logic               req_slot;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] wb_cnt;

  assign wb_cnt   = wb_rd[COUNT_W-1:0];
  assign issue_id = SCAN_ID;
  assign busy     = (state != IDLE) && (state != FINISH);
  assign done     = (state == FINISH);
  assign wb_ack   = outstanding & wb_done;
  // A new request may only go out once the previous response has been consumed.
  assign req_slot = ~outstanding & issue_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    issue_new_request = 1'b0;
    toggle_lock       = 1'b0;
    field_id          = FIELD_ADDR;
    case (state)
      IDLE: if (start) state_nxt = locked ? RD_VALID : LOCK_REQ;
      LOCK_REQ: begin
        toggle_lock       = 1'b1;
        issue_new_request = req_slot;
        if (req_slot) state_nxt = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        toggle_lock = 1'b1;
        if (wb_ack) state_nxt = RD_VALID;
      end
      RD_VALID: begin
        field_id          = FIELD_VALID;
        issue_new_request = req_slot;
        if (wb_ack) state_nxt = wb_rd[0] ? RD_COUNT : NEXT;
      end
      RD_COUNT: begin
        field_id          = FIELD_COUNT;
        issue_new_request = req_slot;
        if (wb_ack) state_nxt = (!best_valid || (wb_cnt > best_count)) ? RD_ADDR : NEXT;
      end
      RD_ADDR: begin
        field_id          = FIELD_ADDR;
        issue_new_request = req_slot;
        if (wb_ack) state_nxt = NEXT;
      end
      NEXT: begin
        if (entry_index == LAST_IDX) state_nxt = unlock_latched ? UNLOCK_REQ : FINISH;
        else                         state_nxt = RD_VALID;
      end
      UNLOCK_REQ: begin
        toggle_lock       = 1'b1;
        issue_new_request = req_slot;
        if (req_slot) state_nxt = UNLOCK_WAIT;
      end
      UNLOCK_WAIT: begin
        toggle_lock = 1'b1;
        if (wb_ack) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding    <= 1'b0;
      unlock_latched <= 1'b0;
      entry_index    <= '0;
      cnt_q          <= '0;
      locked         <= 1'b1;
      best_valid     <= 1'b0;
      best_index     <= '0;
      best_count     <= '0;
      best_addr      <= '0;
    end else begin
      if (issue_new_request) outstanding <= 1'b1;
      else if (wb_ack)       outstanding <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            unlock_latched <= unlock_on_finish;
            entry_index    <= '0;
            best_valid     <= 1'b0;
            best_index     <= '0;
            best_count     <= '0;
            best_addr      <= '0;
          end
        end
        LOCK_WAIT, UNLOCK_WAIT: if (wb_ack) locked <= ~locked;
        RD_COUNT: if (wb_ack) cnt_q <= wb_cnt;
        // The winning entry is committed as a whole once its address arrives.
        RD_ADDR: begin
          if (wb_ack) begin
            best_addr  <= wb_rd;
            best_count <= cnt_q;
            best_index <= entry_index;
            best_valid <= 1'b1;
          end
        end
        NEXT: if (entry_index != LAST_IDX) entry_index <= entry_index + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_profile_scanner.sv
// tb/tb_rca_profile_scanner.sv - scoreboard bench for rca_profile_scanner with a profiler responder model
module tb_rca_profile_scanner;

  logic        clk = 1'b0;
  logic        rst, start, unlock_on_finish, issue_ready;
  logic        issue_new_request, toggle_lock, wb_ack, busy, done, locked, best_valid;
  logic [2:0]  issue_id, entry_index, best_index;
  logic [1:0]  field_id;
  logic        resp_done, spur_done;
  logic [31:0] resp_rd, best_addr;
  logic [7:0]  best_count;
  wire         wb_done = resp_done | spur_done;

  always #5 clk = ~clk;

  rca_profile_scanner dut (
    .clk(clk), .rst(rst), .start(start), .unlock_on_finish(unlock_on_finish),
    .issue_ready(issue_ready), .issue_new_request(issue_new_request), .issue_id(issue_id),
    .toggle_lock(toggle_lock), .field_id(field_id), .entry_index(entry_index),
    .wb_done(wb_done), .wb_rd(resp_rd), .wb_ack(wb_ack), .busy(busy), .done(done),
    .locked(locked), .best_valid(best_valid), .best_index(best_index),
    .best_count(best_count), .best_addr(best_addr)
  );

  typedef struct { logic tg; logic [1:0] fid; logic [2:0] idx; } req_t;
  typedef struct { logic bv; logic [2:0] bi; logic [7:0] bc; logic [31:0] ba; logic lk; } res_t;

  req_t exp_req_q[$];
  res_t exp_res_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_stall = 0;
  int   resp_lat    = 0;

  logic        mem_valid [8];
  logic [31:0] mem_cnt   [8];
  logic [31:0] mem_addr  [8];

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin
      mem_valid[i] = 1'b0;
      mem_cnt[i]   = 32'h0000_00FF;
      mem_addr[i]  = 32'hBAD0_0000 | i;
    end
  endtask

  // Upper count bits are junk that shrinks with index, so only the low 8 bits may be compared.
  task automatic load(input int idx, input logic [7:0] cnt, input logic [31:0] addr);
    mem_valid[idx] = 1'b1;
    mem_cnt[idx]   = {24'hFFFFFF - 24'(idx), cnt};
    mem_addr[idx]  = addr;
  endtask

  function automatic logic [31:0] resp_data(input logic tg, input logic [1:0] fid, input logic [2:0] idx);
    if (tg) return 32'hDEAD_BEEF;
    case (fid)
      2'd1:    return mem_valid[idx] ? 32'h8000_0001 : 32'h7FFF_FFFE;
      2'd2:    return mem_cnt[idx];
      2'd0:    return mem_addr[idx];
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_req(input logic tg, input logic [1:0] fid, input logic [2:0] idx);
    req_t r;
    r.tg = tg; r.fid = fid; r.idx = idx;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rd(input int idx, input logic has_cnt, input logic has_addr);
    push_req(1'b0, 2'd1, 3'(idx));
    if (has_cnt)  push_req(1'b0, 2'd2, 3'(idx));
    if (has_addr) push_req(1'b0, 2'd0, 3'(idx));
  endtask

  task automatic push_res(input logic bv, input logic [2:0] bi, input logic [7:0] bc,
                          input logic [31:0] ba, input logic lk);
    res_t r;
    r.bv = bv; r.bi = bi; r.bc = bc; r.ba = ba; r.lk = lk;
    exp_res_q.push_back(r);
  endtask

  // Profiler responder
  initial begin
    logic       tg;
    logic [1:0] fid;
    logic [2:0] idx;
    int         n;
    resp_done   = 1'b0;
    resp_rd     = 32'h0;
    issue_ready = 1'b0;
    forever begin
      if (ready_stall > 0) begin
        issue_ready = 1'b0;
        repeat (ready_stall) @(posedge clk);
        #1;
      end
      issue_ready = 1'b1;
      @(negedge clk);
      while (!(issue_new_request && !rst)) @(negedge clk);
      tg = toggle_lock; fid = field_id; idx = entry_index;
      @(posedge clk);
      repeat (resp_lat) @(posedge clk);
      #1;
      if (!rst) begin
        resp_done = 1'b1;
        resp_rd   = resp_data(tg, fid, idx);
        n = 0;
        @(negedge clk);
        while (!wb_ack && !rst && n < 20) begin
          n++;
          @(negedge clk);
        end
        n_checks++;
        if (!wb_ack && !rst) begin
          n_fail++;
          $display("FAIL ack_timeout: wb_ack=%0d after %0d cycles, required 1", wb_ack, n);
        end
        @(posedge clk);
        #1;
        resp_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic out_flag;
    req_t e;
    res_t r;
    out_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_flag = 1'b0;
      end else begin
        if (issue_new_request) begin
          n_checks++;
          if (out_flag) begin
            n_fail++;
            $display("FAIL req_outstanding: request at idx=%0d fid=%0d while one outstanding, required none",
                     entry_index, field_id);
          end else if (exp_req_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_unexpected: got tg=%0d fid=%0d idx=%0d, required no request",
                     toggle_lock, field_id, entry_index);
          end else begin
            e = exp_req_q.pop_front();
            if (toggle_lock !== e.tg || issue_id !== 3'd0 ||
                (!e.tg && (field_id !== e.fid || entry_index !== e.idx))) begin
              n_fail++;
              $display("FAIL req: got tg=%0d fid=%0d idx=%0d id=%0d, required tg=%0d fid=%0d idx=%0d id=0",
                       toggle_lock, field_id, entry_index, issue_id, e.tg, e.fid, e.idx);
            end
          end
          out_flag = 1'b1;
        end else if (wb_ack) begin
          if (!out_flag) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_ack: wb_ack=1 with nothing outstanding, required 0");
          end
          out_flag = 1'b0;
        end
        if (done) begin
          n_checks++;
          if (exp_res_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: done=1, required no completion");
          end else begin
            r = exp_res_q.pop_front();
            if ({best_valid, best_index, best_count, best_addr, locked, busy} !==
                {r.bv, r.bi, r.bc, r.ba, r.lk, 1'b0}) begin
              n_fail++;
              $display("FAIL result: got bv=%0d bi=%0d bc=%0d ba=%h lk=%0d busy=%0d, required bv=%0d bi=%0d bc=%0d ba=%h lk=%0d busy=0",
                       best_valid, best_index, best_count, best_addr, locked, busy,
                       r.bv, r.bi, r.bc, r.ba, r.lk);
            end
          end
        end
      end
    end
  end

  task automatic do_start(input logic u);
    @(posedge clk);
    #1 start = 1'b1; unlock_on_finish = u;
    @(posedge clk);
    #1 start = 1'b0; unlock_on_finish = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s done_timeout: done=0 after %0d cycles, required 1", name, n);
    end
    @(negedge clk);
    n_checks++;
    if (done || busy || exp_req_q.size() != 0 || exp_res_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s after_done: done=%0d busy=%0d pending_req=%0d pending_res=%0d, required all 0",
               name, done, busy, exp_req_q.size(), exp_res_q.size());
    end
    exp_req_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; unlock_on_finish = 1'b0; spur_done = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, locked, best_valid, best_index, best_count, best_addr, issue_new_request, wb_ack} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 32'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: busy=%0d done=%0d locked=%0d bv=%0d bi=%0d bc=%0d ba=%h req=%0d ack=%0d, required locked=1 rest 0",
               busy, done, locked, best_valid, best_index, best_count, best_addr, issue_new_request, wb_ack);
    end

    // 1: all invalid, stays locked
    for (int i = 0; i < 8; i++) push_rd(i, 1'b0, 1'b0);
    push_res(1'b0, 3'd0, 8'd0, 32'h0, 1'b1);
    do_start(1'b0);
    wait_done("t1");

    // 2: entries 2 and 5, start pulse while busy must be ignored
    clear_mem();
    load(2, 8'd3, 32'h100);
    load(5, 8'd7, 32'h200);
    for (int i = 0; i < 8; i++) push_rd(i, (i == 2 || i == 5), (i == 2 || i == 5));
    push_res(1'b1, 3'd5, 8'd7, 32'h200, 1'b1);
    do_start(1'b0);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; unlock_on_finish = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; unlock_on_finish = 1'b0;
    wait_done("t2");

    // 3: tie on count 6 keeps entry 1; unlock at end
    clear_mem();
    load(1, 8'd6, 32'h110);
    load(4, 8'd6, 32'h140);
    load(6, 8'd5, 32'h160);
    for (int i = 0; i < 8; i++) push_rd(i, (i == 1 || i == 4 || i == 6), (i == 1));
    push_req(1'b1, 2'd0, 3'd0);
    push_res(1'b1, 3'd1, 8'd6, 32'h110, 1'b0);
    do_start(1'b1);
    wait_done("t3");

    // 4: starts unlocked, lock then unlock; count 0 still wins as first valid
    clear_mem();
    load(0, 8'd0, 32'h10);
    load(7, 8'd9, 32'h700);
    push_req(1'b1, 2'd0, 3'd0);
    for (int i = 0; i < 8; i++) push_rd(i, (i == 0 || i == 7), (i == 0 || i == 7));
    push_req(1'b1, 2'd0, 3'd0);
    push_res(1'b1, 3'd7, 8'd9, 32'h700, 1'b0);
    do_start(1'b1);
    wait_done("t4");

    // 5: slow responder and issue_ready stalls, same data as case 2
    clear_mem();
    load(2, 8'd3, 32'h100);
    load(5, 8'd7, 32'h200);
    resp_lat = 5;
    ready_stall = 3;
    push_req(1'b1, 2'd0, 3'd0);
    for (int i = 0; i < 8; i++) push_rd(i, (i == 2 || i == 5), (i == 2 || i == 5));
    push_res(1'b1, 3'd5, 8'd7, 32'h200, 1'b1);
    do_start(1'b0);
    wait_done("t5");

    // 6: reset during the count read of entry 3, then spurious wb_done in IDLE
    resp_lat = 0;
    ready_stall = 0;
    clear_mem();
    load(0, 8'd4, 32'h40);
    load(3, 8'd2, 32'h30);
    push_rd(0, 1'b1, 1'b1);
    push_rd(1, 1'b0, 1'b0);
    push_rd(2, 1'b0, 1'b0);
    push_rd(3, 1'b1, 1'b0);
    do_start(1'b0);
    n = 0;
    @(negedge clk);
    while (!(issue_new_request && field_id == 2'd2 && entry_index == 3'd3) && n < 500) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n >= 500) begin
      n_fail++;
      $display("FAIL t6 reach_count3: count read of entry 3 not seen in %0d cycles, required", n);
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, best_valid, locked, done} !== 4'b0010) begin
      n_fail++;
      $display("FAIL t6 reset_abort: busy=%0d bv=%0d locked=%0d done=%0d, required busy=0 bv=0 locked=1 done=0",
               busy, best_valid, locked, done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (exp_req_q.size() != 0) begin
      n_fail++;
      $display("FAIL t6 pending_req: %0d expected requests never issued, required 0", exp_req_q.size());
    end
    exp_req_q.delete();
    @(posedge clk);
    #1 spur_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wb_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL t6 spurious_done: wb_ack=%0d, required 0", wb_ack);
    end
    @(posedge clk);
    #1 spur_done = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
